// File: rtl/muldiv_pkg.sv
// Shared encodings and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // funct3 encodings of the M-extension ops.
  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_div(logic [2:0] op);
    return op[2];
  endfunction

  // DIV/REM and MUL/MULH/MULHSU treat rs1 as signed.
  function automatic logic is_signed_a(logic [2:0] op);
    return op[2] ? !op[0] : (op[1:0] != 2'd3);
  endfunction

  // DIV/REM and MUL/MULH treat rs2 as signed.
  function automatic logic is_signed_b(logic [2:0] op);
    return op[2] ? !op[0] : !op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational Bpc-deep iteration: shift-add multiply or restoring divide on magnitudes.
// Accumulator layout: {upper (Xlen+1 bits), lower (Xlen bits)}.
//   multiply: upper = partial product, lower = remaining multiplier bits (LSB first)
//   divide:   upper = partial remainder, lower = dividend bits shifting into quotient
module muldiv_step #(
  parameter int unsigned Xlen = 32,
  parameter int unsigned Bpc  = 1
) (
  input  logic [2*Xlen:0] acc_i,
  input  logic [Xlen:0]   opnd_i,
  input  logic            div_i,
  output logic [2*Xlen:0] acc_o
);

  // Unrolled Bpc iterations of the selected algorithm.
  always_comb begin
    logic [2*Xlen:0] acc;
    logic [Xlen:0]   part;
    logic [Xlen-1:0] low;
    acc  = acc_i;
    part = '0;
    low  = '0;
    for (int unsigned i = 0; i < Bpc; i++) begin
      if (div_i) begin
        // Partial remainder stays below the divisor, so its top bit is always zero here.
        part = {acc[2*Xlen-1:Xlen], acc[Xlen-1]};
        low  = {acc[Xlen-2:0], 1'b0};
        if (part >= opnd_i) begin
          part   = part - opnd_i;
          low[0] = 1'b1;
        end
        acc = {part, low};
      end else begin
        part = acc[2*Xlen:Xlen];
        low  = acc[Xlen-1:0];
        if (low[0]) begin
          part = part + opnd_i;
        end
        acc = {part, low} >> 1;
      end
    end
    acc_o = acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshake and jump flush.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            jump,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned ITER    = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW    = $clog2(ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN:0]   acc_q, acc_d, acc_step;
  logic [XLEN:0]     opnd_q, opnd_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand magnitudes in XLEN+1 bits so the most-negative value negates cleanly.
  logic              a_neg, b_neg, div_by_zero, overflow;
  logic [XLEN:0]     a_ext, b_ext, a_mag, b_mag;

  assign a_neg = is_signed_a(op_in) && a_in[XLEN-1];
  assign b_neg = is_signed_b(op_in) && b_in[XLEN-1];
  assign a_ext = {a_neg, a_in};
  assign b_ext = {b_neg, b_in};
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign div_by_zero = is_div(op_in) && (b_in == '0);
  assign overflow    = is_div(op_in) && !op_in[0] && (b_in == '1) &&
                       (a_in == {1'b1, {(XLEN-1){1'b0}}});

  muldiv_step #(
    .Xlen (XLEN),
    .Bpc  (BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div(op_q)),
    .acc_o  (acc_step)
  );

  // Sign fix-up and word selection on the final iteration's accumulator.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, quo_s, rem, rem_s, final_res;

  always_comb begin
    prod   = acc_step[2*XLEN-1:0];
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quo    = acc_step[XLEN-1:0];
    rem    = acc_step[2*XLEN-1:XLEN];
    quo_s  = (sa_q ^ sb_q) ? -quo : quo;
    rem_s  = sa_q ? -rem : rem;
    if (is_div(op_q)) begin
      final_res = op_q[1] ? rem_s : quo_s;
    end else begin
      final_res = (op_q == OpMul) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; jump overrides accept, iterate and retire.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = op_in;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          if (div_by_zero) begin
            result_d = op_in[1] ? a_in : '1;
            state_d  = StDone;
          end else if (overflow) begin
            result_d = op_in[1] ? '0 : a_in;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
            if (is_div(op_in)) begin
              acc_d  = {{(XLEN+1){1'b0}}, a_mag[XLEN-1:0]};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{(XLEN+1){1'b0}}, b_mag[XLEN-1:0]};
              opnd_d = a_mag;
            end
          end
        end
      end
      StCalc: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (jump) begin
      state_d = StIdle;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit/1-bit-per-cycle and a 64-bit/4-bit-per-cycle instance.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, jump;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op_in;
  logic [31:0] a_in, b_in, result;

  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready, v64_busy;
  logic [2:0]  v64_op;
  logic [63:0] v64_a, v64_b, v64_result;

  int n_total = 0;
  int n_pass  = 0;

  muldiv_unit #(
    .XLEN           (32),
    .BITS_PER_CYCLE (1)
  ) u_dut32 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_in     (op_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .jump      (jump),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  muldiv_unit #(
    .XLEN           (64),
    .BITS_PER_CYCLE (4)
  ) u_dut64 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (v64_in_valid),
    .in_ready  (v64_in_ready),
    .op_in     (v64_op),
    .a_in      (v64_a),
    .b_in      (v64_b),
    .jump      (jump),
    .out_valid (v64_out_valid),
    .out_ready (v64_out_ready),
    .result    (v64_result),
    .busy      (v64_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue32(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
    op_in    = op;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge up to the edge that raised out_valid.
  task automatic await32(output int lat, output logic saw_ready);
    lat       = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      saw_ready |= in_ready;
      tick();
      lat++;
    end
  endtask

  task automatic retire32(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, in_ready, 1);
  endtask

  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic saw;
    issue32(tag, op, a, b);
    await32(lat, saw);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, result, exp);
    if (exp_lat != 0) check({tag, "_lat"}, lat, exp_lat);
    retire32(tag);
  endtask

  task automatic run64(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int n = 0;
    int lat;
    while (!v64_in_ready && n < 100) begin
      tick();
      n++;
    end
    v64_op       = op;
    v64_a        = a;
    v64_b        = b;
    v64_in_valid = 1'b1;
    tick();
    v64_in_valid = 1'b0;
    lat = 1;
    while (!v64_out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_valid"}, v64_out_valid, 1);
    check(tag, v64_result, exp);
    if (exp_lat != 0) check({tag, "_lat"}, lat, exp_lat);
    v64_out_ready = 1'b1;
    tick();
    v64_out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    logic saw;

    reset = 1'b0; jump = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op_in = '0; a_in = '0; b_in = '0;
    v64_in_valid = 1'b0; v64_out_ready = 1'b0; v64_op = '0; v64_a = '0; v64_b = '0;
    repeat (2) tick();
    reset = 1'b1;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);

    // MUL 7 * -3 with full latency and in_ready low until done.
    issue32("mul", MUL, 32'd7, -32'sd3);
    await32(lat, saw);
    check("mul_valid", out_valid, 1);
    check("mul", result, 32'hFFFF_FFEB);
    check("mul_lat", lat, 33);
    check("mul_ready_low", saw, 0);
    retire32("mul");

    run32("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run32("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run32("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run32("mul_lo", MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 0);
    run32("div", DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
    run32("rem", REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 0);
    run32("divu", DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0);
    run32("divu_small", DIVU, 32'd100, 32'd7, 32'd14, 0);
    run32("remu_small", REMU, 32'd100, 32'd7, 32'd2, 0);

    // Architected special cases bypass CALC.
    run32("div_by0", DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run32("remu_by0", REMU, 32'h1234, 32'd0, 32'h0000_1234, 1);
    run32("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run32("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Backpressure: result and out_valid hold while out_ready is low.
    issue32("bp", MUL, 32'd3, 32'd5);
    await32(lat, saw);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 32'd15);
      tick();
    end
    retire32("bp");

    // jump in IDLE masks a simultaneous in_valid.
    op_in = MUL; a_in = 32'd2; b_in = 32'd2;
    in_valid = 1'b1; jump = 1'b1;
    tick();
    in_valid = 1'b0; jump = 1'b0;
    check("jump_idle_ready", in_ready, 1);
    check("jump_idle_busy", busy, 0);

    // jump mid-CALC kills the op.
    issue32("jcalc", DIVU, 32'd1000, 32'd10);
    repeat (10) tick();
    check("jcalc_busy", busy, 1);
    jump = 1'b1;
    tick();
    jump = 1'b0;
    check("jcalc_ready", in_ready, 1);
    saw = 1'b0;
    repeat (40) begin
      saw |= out_valid;
      tick();
    end
    check("jcalc_no_valid", saw, 0);
    run32("after_jump", DIV, 32'd100, -32'sd7, 32'hFFFF_FFF2, 33);

    // Reset mid-CALC behaves the same way.
    issue32("rcalc", DIVU, 32'd1000, 32'd10);
    repeat (10) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rcalc_ready", in_ready, 1);
    check("rcalc_result", result, 0);
    saw = 1'b0;
    repeat (40) begin
      saw |= out_valid;
      tick();
    end
    check("rcalc_no_valid", saw, 0);
    run32("after_reset", REM, -32'sd100, 32'd7, 32'hFFFF_FFFE, 33);

    // 64-bit, 4 bits per cycle.
    run64("divu64", DIVU, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 17);
    run64("mulhu64", MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 17);
    run64("mulhsu64", MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF, 0);
    run64("rem64", REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run64("mul64", MUL, 64'h1_0000_0001, -64'sd2, 64'hFFFF_FFFD_FFFF_FFFE, 0);
    run64("div64_by0", DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
